// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: turns an operation plus register/immediate fields into a
// 32-bit instruction word, tags it with a running byte address, and buffers it in a
// 2-entry FIFO. Illegal operations are consumed and counted instead of being encoded.
module mips_instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned WordW = 32;
    localparam int unsigned OccW  = 2;
    localparam int unsigned CntW  = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_AND  = 4'd1,
        OP_JR   = 4'd2,
        OP_LW   = 4'd3,
        OP_SW   = 4'd4,
        OP_BEQ  = 4'd5,
        OP_BNE  = 4'd6,
        OP_J    = 4'd7,
        OP_JAL  = 4'd8,
        OP_ADDI = 4'd9,
        OP_ANDI = 4'd10
    } op_e;

    typedef struct packed {
        logic [WordW-1:0] word;
        logic [WordW-1:0] addr;
    } entry_t;

    // Registered state
    logic [OccW-1:0]  occ_q,     occ_d;
    entry_t           head_q,    head_d;
    entry_t           tail_q,    tail_d;
    logic [WordW-1:0] cnt_q,     cnt_d;
    logic             err_q,     err_d;
    logic [CntW-1:0]  err_cnt_q, err_cnt_d;
    logic             vld_q,     vld_d;
    logic             rdy_q,     rdy_d;

    // Combinational helpers
    logic [WordW-1:0] enc_c;
    logic             legal_c;
    logic             accept_c;
    logic             push_c;
    logic             bad_c;
    logic             pop_c;
    logic [WordW-1:0] addr_sel_c;
    entry_t           new_entry_c;

    // Encode the requested operation; fields an op does not use are forced to zero
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (op_e'(in_op))
            OP_ADD:  enc_c = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
            OP_AND:  enc_c = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
            OP_JR:   enc_c = {6'b000000, in_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            OP_LW:   enc_c = {6'b100011, in_rs, in_rt, in_imm};
            OP_SW:   enc_c = {6'b101011, in_rs, in_rt, in_imm};
            OP_BEQ:  enc_c = {6'b000100, in_rs, in_rt, in_imm};
            OP_BNE:  enc_c = {6'b000101, in_rs, in_rt, in_imm};
            OP_J:    enc_c = {6'b000010, in_target};
            OP_JAL:  enc_c = {6'b000011, in_target};
            OP_ADDI: enc_c = {6'b001000, in_rs, in_rt, in_imm};
            OP_ANDI: enc_c = {6'b001100, in_rs, in_rt, in_imm};
            default: legal_c = 1'b0;
        endcase
    end

    // Handshakes, address counter, FIFO and error bookkeeping next-state
    always_comb begin
        accept_c    = in_valid & rdy_q;
        push_c      = accept_c & legal_c;
        bad_c       = accept_c & ~legal_c;
        pop_c       = vld_q & inst_ready;
        addr_sel_c  = base_load ? base_addr : cnt_q;
        new_entry_c = '{word: enc_c, addr: addr_sel_c};

        occ_d     = occ_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        cnt_d     = push_c ? (addr_sel_c + WordW'(4)) : addr_sel_c;

        // push is only possible with occupancy below two, so head/tail cover all cases
        case ({push_c, pop_c})
            2'b10: begin
                if (occ_q == OccW'(0)) head_d = new_entry_c;
                else                   tail_d = new_entry_c;
                occ_d = occ_q + OccW'(1);
            end
            2'b01: begin
                if (occ_q == OccW'(2)) head_d = tail_q;
                occ_d = occ_q - OccW'(1);
            end
            2'b11: begin
                if (occ_q == OccW'(2)) begin
                    head_d = tail_q;
                    tail_d = new_entry_c;
                end else begin
                    head_d = new_entry_c;
                end
            end
            default: ;
        endcase

        if (bad_c) begin
            err_d = 1'b1;
            if (err_cnt_q != {CntW{1'b1}}) err_cnt_d = err_cnt_q + CntW'(1);
        end

        vld_d = (occ_d != OccW'(0));
        rdy_d = (occ_d != OccW'(2));
    end

    // State register with asynchronous active-low reset; reset drops any buffered words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            vld_q     <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            occ_q     <= occ_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            vld_q     <= vld_d;
            rdy_q     <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign inst_valid = vld_q;
    assign inst       = head_q.word;
    assign inst_addr  = head_q.addr;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with hand-computed instruction words and addresses.
module tb_mips_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        base_load;
    logic [31:0] base_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    mips_instr_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request; garbage in unused fields must not leak into the word
    task automatic req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        base_load = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        inst_ready = 1'b1;
        #2 rst = 1'b0;
        #3;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; base_load = 1'b0; base_addr = '0; inst_ready = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Reset state
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",       inst,            32'h0);
        chk("rst_inst_addr",  inst_addr,       32'h0);
        chk("rst_err",        32'(err),        32'd0);
        chk("rst_err_cnt",    32'(err_cnt),    32'd0);

        // Single ADD, visible one cycle after acceptance
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h155_5555);
        step(); idle();
        chk("add_valid", 32'(inst_valid), 32'd1);
        chk("add_inst",  inst,            32'h0022_1820);
        chk("add_addr",  inst_addr,       32'h0);
        step();
        chk("add_drained", 32'(inst_valid), 32'd0);

        // LW then JAL then AND back-to-back with the sink always ready
        do_reset();
        req(4'd3, 5'd29, 5'd8, 5'd31, 16'h0004, 26'h3FF_FFFF);
        step();
        chk("lw_inst", inst,      32'h8FA8_0004);
        chk("lw_addr", inst_addr, 32'h0);
        req(4'd8, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h000_0010);
        step();
        chk("jal_inst", inst,      32'h0C00_0010);
        chk("jal_addr", inst_addr, 32'h4);
        req(4'd1, 5'd6, 5'd7, 5'd8, 16'hFFFF, 26'h3FF_FFFF);
        step(); idle();
        chk("and_inst", inst,      32'h00C7_4024);
        chk("and_addr", inst_addr, 32'h8);
        step();
        chk("and_drained", 32'(inst_valid), 32'd0);

        // Backpressure: two accepts fill the FIFO, the third waits for space
        do_reset();
        inst_ready = 1'b0;
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step();
        req(4'd2, 5'd31, 5'd5, 5'd7, 16'hBEEF, 26'h2AA_AAAA);
        step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        req(4'd7, 5'd9, 5'd9, 5'd9, 16'h9999, 26'h3FF_FFFF);
        step();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_inst",     inst,          32'h0022_1820);
        chk("stall_addr",     inst_addr,     32'h0);
        inst_ready = 1'b1;
        step();
        chk("drain1_inst",     inst,          32'h03E0_0008);
        chk("drain1_addr",     inst_addr,     32'h4);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        step(); idle();
        chk("third_inst", inst,      32'h0BFF_FFFF);
        chk("third_addr", inst_addr, 32'h8);
        step();
        chk("bp_drained", 32'(inst_valid), 32'd0);

        // Illegal op: consumed, flagged, counter untouched
        do_reset();
        req(4'd15, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
        step(); idle();
        chk("ill_err",     32'(err),        32'd1);
        chk("ill_err_cnt", 32'(err_cnt),    32'd1);
        chk("ill_valid",   32'(inst_valid), 32'd0);
        req(4'd9, 5'd2, 5'd3, 5'd31, 16'h8000, 26'h3FF_FFFF);
        step(); idle();
        chk("addi_inst", inst,      32'h2043_8000);
        chk("addi_addr", inst_addr, 32'h0);
        chk("err_sticky", 32'(err), 32'd1);

        // base_load together with a push
        do_reset();
        base_load = 1'b1;
        base_addr = 32'h0040_0000;
        req(4'd5, 5'd4, 5'd5, 5'd17, 16'hFFFF, 26'h0);
        step();
        base_load = 1'b0;
        chk("beq_inst", inst,      32'h1085_FFFF);
        chk("beq_addr", inst_addr, 32'h0040_0000);
        req(4'd4, 5'd0, 5'd1, 5'd2, 16'h0010, 26'h3FF_FFFF);
        step(); idle();
        chk("sw_inst", inst,      32'hAC01_0010);
        chk("sw_addr", inst_addr, 32'h0040_0004);
        step();

        // Address counter wrap-around
        base_load = 1'b1;
        base_addr = 32'hFFFF_FFFC;
        step();
        base_load = 1'b0;
        chk("load_only_no_valid", 32'(inst_valid), 32'd0);
        req(4'd10, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0);
        step();
        chk("andi_inst", inst,      32'h3022_00FF);
        chk("andi_addr", inst_addr, 32'hFFFF_FFFC);
        req(4'd6, 5'd3, 5'd4, 5'd0, 16'h0001, 26'h0);
        step(); idle();
        chk("bne_inst", inst,      32'h1464_0001);
        chk("bne_addr", inst_addr, 32'h0);
        step();

        // Saturating illegal-op counter
        do_reset();
        req(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 260; i++) step();
        idle();
        chk("err_cnt_sat", 32'(err_cnt),    32'd255);
        chk("sat_no_valid", 32'(inst_valid), 32'd0);

        // Reset mid-operation discards buffered words
        do_reset();
        inst_ready = 1'b0;
        req(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        step();
        req(4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
        step(); idle();
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(inst_valid), 32'd0);
        chk("async_addr",  inst_addr,       32'h0);
        @(negedge clk);
        rst = 1'b1;
        inst_ready = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready),   32'd1);
        chk("post_rst_no_word",  32'(inst_valid), 32'd0);
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step(); idle();
        chk("post_rst_inst", inst,      32'h0022_1820);
        chk("post_rst_addr", inst_addr, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  encode request present.
REQ-004 SHALL have port in_ready  output  1  request accepted on clk edge when in_valid & in_ready.
REQ-005 SHALL have port in_op  input  4  operation: 0 ADD, 1 AND, 2 JR, 3 LW, 4 SW, 5 BEQ, 6 BNE, 7 J, 8 JAL, 9 ADDI, 10 ANDI; 11-15 illegal.
REQ-006 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-007 SHALL have port in_imm  input  16  immediate / branch offset.
REQ-008 SHALL have port in_target  input  26  jump target field.
REQ-009 SHALL have port base_load  input  1  load address counter from base_addr.
REQ-010 SHALL have port base_addr  input  32  new instruction base address.
REQ-011 SHALL have port inst_valid  output  1  encoded word available.
REQ-012 SHALL have port inst_ready  input  1  sink consumes word when inst_valid & inst_ready.
REQ-013 SHALL have port inst  output  32  encoded MIPS instruction word.
REQ-014 SHALL have port inst_addr  output  32  byte address of inst.
REQ-015 SHALL have port err  output  1  sticky illegal-op flag.
REQ-016 SHALL have port err_cnt  output  8  count of illegal ops received.

Function
REQ-017 Encoding SHALL be: ADD/AND -> opcode 000000, rs, rt, rd, shamt 0, funct 100000/100100; JR -> opcode 000000, rs, rt=0, rd=0, shamt 0, funct 001000.
REQ-018 Encoding SHALL be: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100 -> {opcode, rs, rt, imm}; J 000010, JAL 000011 -> {opcode, target}.
REQ-019 Unused input fields SHALL be ignored (forced to zero per REQ-017, not passed through).
REQ-020 Output buffering SHALL be a 2-entry FIFO of {inst, inst_addr}; in_ready = (occupancy < 2), registered-state-derived, no combinational path from inst_ready.
REQ-021 A legal accepted request SHALL be enqueued on that edge; inst_valid = (occupancy > 0); earliest visibility one cycle after acceptance.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; push when full SHALL be impossible (in_ready low).
REQ-023 Address counter SHALL tag each enqueued word with its current value, then add 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-024 base_load SHALL load the counter with base_addr; if a legal push occurs in the same cycle, that word SHALL take base_addr and counter SHALL become base_addr+4.
REQ-025 An illegal in_op, when accepted, SHALL be consumed (not enqueued, counter unchanged), set err, and increment err_cnt saturating at 255.
REQ-026 err SHALL remain 1 until reset; illegal op when full SHALL wait for in_ready like any request.
REQ-027 inst and inst_addr SHALL hold stable while inst_valid & !inst_ready.

Reset
REQ-028 On rst low, asynchronously: occupancy 0, inst_valid 0, in_ready 1 after release, address counter 0x00000000, err 0, err_cnt 0, inst 0, inst_addr 0.
REQ-029 Reset mid-operation SHALL discard all buffered words; no word SHALL emerge after release until a new request is accepted.

Verification
REQ-030 ADD rs=1 rt=2 rd=3 after reset, inst_ready=1 -> inst=0x00221820, inst_addr=0x00000000, one cycle later.
REQ-031 LW rs=29 rt=8 imm=0x0004 then JAL target=0x0000010 -> 0x8FA80004 @0x0, then 0x0C000010 @0x4.
REQ-032 inst_ready=0, three back-to-back requests -> in_ready low after two accepts; releasing inst_ready drains addresses 0x0, 0x4, then third accepted at 0x8.
REQ-033 in_op=15 accepted -> err=1, err_cnt=1, no inst_valid, next legal word still at address 0x0.
REQ-034 base_load with base_addr=0x00400000 plus simultaneous BEQ rs=4 rt=5 imm=0xFFFF -> inst=0x1085FFFF @0x00400000; next word @0x00400004.
REQ-035 rst asserted with two buffered words -> inst_valid 0 immediately, counter 0; first post-reset word at 0x0.
